// File: rtl/instruction_fetch.sv
// RV32I IF stage: PC generation, 1-cycle BRAM read, one-entry skid buffer and redirect handling.
// Optional FETCH_PERF_COUNTERS_EN adds the perf_fetched/perf_stalled counters (tied to 0 otherwise).
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  output logic        im_re,
  input  logic [31:0] im_data,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        exception_fetch_misaligned,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalled
);

  // Handshake: an output beat is transferred on every cycle with valid_out=1
  // and stall=0; with stall=1 the same beat is presented again next cycle.
  // A redirect kills whatever is shown in its own cycle.

  logic [31:0] fetch_pc;
  logic        pending_valid;
  logic [31:0] pending_pc;
  logic        pending_fault;
  logic        hold_valid;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;
  logic        hold_fault;
  logic        issue;
  logic [31:0] pending_inst;

  assign im_addr      = redirect ? redirect_pc : fetch_pc;
  assign issue        = redirect | ~stall;
  assign im_re        = issue & (im_addr[1:0] == 2'b00);
  assign pending_inst = pending_fault ? NOP_INST : im_data;
  assign valid_out    = (hold_valid | pending_valid) & ~reset;

  always_comb begin
    inst_out                   = NOP_INST;
    pc_out                     = pending_pc;
    exception_fetch_misaligned = 1'b0;
    if (hold_valid) begin
      inst_out                   = hold_inst;
      pc_out                     = hold_pc;
      exception_fetch_misaligned = hold_fault;
    end else if (pending_valid) begin
      inst_out                   = pending_inst;
      pc_out                     = pending_pc;
      exception_fetch_misaligned = pending_fault;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc      <= RESET_VECTOR;
      pending_valid <= 1'b0;
      pending_pc    <= RESET_VECTOR;
      pending_fault <= 1'b0;
      hold_valid    <= 1'b0;
      hold_inst     <= NOP_INST;
      hold_pc       <= RESET_VECTOR;
      hold_fault    <= 1'b0;
    end else if (redirect) begin
      hold_valid    <= 1'b0;
      pending_valid <= 1'b1;
      pending_pc    <= redirect_pc;
      pending_fault <= (redirect_pc[1:0] != 2'b00);
      fetch_pc      <= redirect_pc + 32'd4;
    end else if (!stall) begin
      hold_valid    <= 1'b0;
      pending_valid <= 1'b1;
      pending_pc    <= fetch_pc;
      pending_fault <= (fetch_pc[1:0] != 2'b00);
      fetch_pc      <= fetch_pc + 32'd4;
    end else if (pending_valid && !hold_valid) begin
      // BRAM data is only valid for one cycle, so park it before it is lost.
      hold_valid    <= 1'b1;
      hold_inst     <= pending_inst;
      hold_pc       <= pending_pc;
      hold_fault    <= pending_fault;
      pending_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetched_cnt;
  logic [31:0] stalled_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_cnt <= 32'h0;
      stalled_cnt <= 32'h0;
    end else if (valid_out && !redirect) begin
      if (stall) stalled_cnt <= stalled_cnt + 32'd1;
      else       fetched_cnt <= fetched_cnt + 32'd1;
    end
  end

  assign perf_fetched = fetched_cnt;
  assign perf_stalled = stalled_cnt;
`else
  assign perf_fetched = 32'h0;
  assign perf_stalled = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed test-plan steps plus random stall/redirect traffic
// checked against a stream-level model of the instruction sequence seen by decode.
module tb_instruction_fetch;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset / DUT
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] im_addr;
  logic        im_re;
  logic [31:0] im_data = 32'h0;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        exception_fetch_misaligned;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalled;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_VECTOR(RV), .NOP_INST(NOP)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .im_addr(im_addr),
    .im_re(im_re),
    .im_data(im_data),
    .inst_out(inst_out),
    .pc_out(pc_out),
    .valid_out(valid_out),
    .exception_fetch_misaligned(exception_fetch_misaligned),
    .perf_fetched(perf_fetched),
    .perf_stalled(perf_stalled)
  );

  // instruction memory: every word holds its own byte address
  always @(posedge clk) if (im_re) im_data <= im_addr;

  // scoreboard
  int checks = 0;
  int failures = 0;

  // stream model: what decode sees, and which PC follows it
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;
  logic [31:0] m_fetched;
  logic [31:0] m_stalled;
  logic        want_en = 1'b0;
  logic [31:0] want_pc = 32'h0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_pc      = RV;
    m_next    = RV;
    m_fetched = 32'h0;
    m_stalled = 32'h0;
  endtask

  task automatic expect_pc(input logic [31:0] p);
    want_en = 1'b1;
    want_pc = p;
  endtask

  // driver: one clock cycle of stimulus, checks mid-cycle, model steps at the edge
  task automatic cycle(input logic s, input logic r, input logic [31:0] rp);
    logic [31:0] exp_addr;
    @(negedge clk);
    stall = s;
    redirect = r;
    redirect_pc = rp;
    #1;
    check1("valid_out", valid_out, m_valid);
    if (m_valid) begin
      check32("pc_out", pc_out, m_pc);
      check32("inst_out", inst_out, (m_pc[1:0] == 2'b00) ? m_pc : NOP);
      check1("misaligned", exception_fetch_misaligned, m_pc[1:0] != 2'b00);
    end else begin
      check32("inst_idle", inst_out, NOP);
      check1("misaligned_idle", exception_fetch_misaligned, 1'b0);
    end
    exp_addr = r ? rp : m_next;
    check32("im_addr", im_addr, exp_addr);
    check1("im_re", im_re, (r | ~s) & (exp_addr[1:0] == 2'b00));
`ifdef FETCH_PERF_COUNTERS_EN
    check32("perf_fetched", perf_fetched, m_fetched);
    check32("perf_stalled", perf_stalled, m_stalled);
`else
    check32("perf_fetched_tied", perf_fetched, 32'h0);
    check32("perf_stalled_tied", perf_stalled, 32'h0);
`endif
    if (want_en) begin
      check32("pc_directed", pc_out, want_pc);
      want_en = 1'b0;
    end
    @(posedge clk);
    if (m_valid && !r) begin
      if (s) m_stalled = m_stalled + 32'd1;
      else   m_fetched = m_fetched + 32'd1;
    end
    if (r) begin
      m_valid = 1'b1;
      m_pc    = rp;
      m_next  = rp + 32'd4;
    end else if (!s) begin
      m_valid = 1'b1;
      m_pc    = m_next;
      m_next  = m_next + 32'd4;
    end
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check1("reset_valid", valid_out, 1'b0);
    check32("reset_inst", inst_out, NOP);
    check1("reset_misaligned", exception_fetch_misaligned, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] rp;
    logic        s;
    logic        r;

    stall = 1'b0;
    hold_reset();

    // streaming from reset: nothing in cycle 0, then 0, 4, 8
    cycle(1'b0, 1'b0, 32'h0);
    expect_pc(32'h0); cycle(1'b0, 1'b0, 32'h0);
    expect_pc(32'h4); cycle(1'b0, 1'b0, 32'h0);
    // stall three cycles on pc 8, then release with no bubble
    for (int i = 0; i < 3; i++) begin
      expect_pc(32'h8); cycle(1'b1, 1'b0, 32'h0);
    end
    expect_pc(32'h8);  cycle(1'b0, 1'b0, 32'h0);
    expect_pc(32'hC);  cycle(1'b0, 1'b0, 32'h0);
    // fill the skid entry, then redirect on top of a stall
    expect_pc(32'h10); cycle(1'b1, 1'b0, 32'h0);
    expect_pc(32'h10); cycle(1'b1, 1'b1, 32'h100);
    expect_pc(32'h100); cycle(1'b0, 1'b0, 32'h0);
    expect_pc(32'h104); cycle(1'b0, 1'b0, 32'h0);
    // misaligned redirect target
    expect_pc(32'h108); cycle(1'b0, 1'b1, 32'h102);
    expect_pc(32'h102); cycle(1'b0, 1'b0, 32'h0);
    expect_pc(32'h106); cycle(1'b0, 1'b0, 32'h0);
    // PC wrap
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    expect_pc(32'hFFFF_FFFC); cycle(1'b0, 1'b0, 32'h0);
    expect_pc(32'h0);         cycle(1'b0, 1'b0, 32'h0);

    // random stall/redirect traffic
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      rp  = {rnd[31:2], 2'b00};
      if ($urandom_range(0, 3) == 0) rp[1:0] = rnd[1:0];
      if ($urandom_range(0, 7) == 0) rp[31:4] = 28'hFFFF_FFF;
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 11) == 0);
      cycle(s, r, rp);
    end
    cycle(1'b0, 1'b1, 32'h200);

    // asynchronous reset while the skid entry is full
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    #3;
    hold_reset();

    // counters: 5 consumed beats then 3 stalled beats
    stall = 1'b0;
    cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      expect_pc(RV + 32'(4 * i)); cycle(1'b0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #1;
`ifdef FETCH_PERF_COUNTERS_EN
    check32("perf_fetched_total", perf_fetched, 32'd5);
    check32("perf_stalled_total", perf_stalled, 32'd3);
`else
    check32("perf_fetched_total", perf_fetched, 32'd0);
    check32("perf_stalled_total", perf_stalled, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
